// File: rtl/div_pkg.sv
// Shared types and width helpers for the sequential signed divider.
// Provides the FSM state encoding, default widths and saturation constants.
package div_pkg;

  localparam int DEF_DIVIDEND_W = 32;
  localparam int DEF_DIVISOR_W  = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_e;

  // Largest positive two's-complement value of width w (w <= 64).
  function automatic logic [63:0] max_pos(input int w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction

  // Most negative two's-complement value of width w (w <= 64).
  function automatic logic [63:0] min_neg(input int w);
    return 64'd1 << (w - 1);
  endfunction

endpackage

// File: rtl/div32x16_signed_seq_if.sv
// Operand/result bundle of the sequential divider with valid/ready on both sides.
// master = producer/consumer side, slave = divider side.
interface div32x16_signed_seq_if
  import div_pkg::*;
#(
  parameter int DIVIDEND_W = DEF_DIVIDEND_W,
  parameter int DIVISOR_W  = DEF_DIVISOR_W
);

  logic                  in_valid;
  logic                  in_ready;
  logic [DIVIDEND_W-1:0] dividend;
  logic [DIVISOR_W-1:0]  divisor;
  logic                  out_valid;
  logic                  out_ready;
  logic [DIVIDEND_W-1:0] quotient;
  logic [DIVISOR_W-1:0]  remainder;
  logic                  div_by_zero;
  logic                  overflow;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_by_zero, overflow
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_by_zero, overflow
  );

endinterface

// File: rtl/div_sign_mag.sv
// Combinational two's-complement conditional negate, used both as abs() on
// operands and as sign fix-up on results; a pass-through when SIGNED=0.
module div_sign_mag #(
  parameter int W      = 16,
  parameter bit SIGNED = 1'b1
) (
  input  logic [W-1:0] val,
  input  logic         neg,
  output logic [W-1:0] res
);

  assign res = (SIGNED && neg) ? (~val + W'(1)) : val;

endmodule

// File: rtl/div32x16_signed_seq.sv
// Radix-2 restoring divider, one quotient bit per enabled cycle; result valid DIVIDEND_W+2 edges after accept.
// in_ready only in IDLE, result held until out_ready; ce=0 freezes everything. Saturation via `DIV_SAT_EN.
module div32x16_signed_seq
  import div_pkg::*;
#(
  parameter int DIVIDEND_W = DEF_DIVIDEND_W,
  parameter int DIVISOR_W  = DEF_DIVISOR_W,
  parameter bit SIGNED     = 1'b1
) (
  input logic                  clk,
  input logic                  rst_n,
  input logic                  ce,
  div32x16_signed_seq_if.slave bus
);

  localparam int CW = (DIVIDEND_W > 1) ? $clog2(DIVIDEND_W) : 1;

  localparam logic [1:0] S_IDLE = 2'(IDLE);
  localparam logic [1:0] S_CALC = 2'(CALC);
  localparam logic [1:0] S_FIX  = 2'(FIX);
  localparam logic [1:0] S_DONE = 2'(DONE);

  localparam logic [DIVIDEND_W-1:0] D_MIN = DIVIDEND_W'(min_neg(DIVIDEND_W));
`ifdef DIV_SAT_EN
  localparam logic [DIVIDEND_W-1:0] Q_MAX = DIVIDEND_W'(max_pos(DIVIDEND_W));
`endif

  logic [1:0]            state;
  logic [CW-1:0]         cnt;
  logic [DIVIDEND_W-1:0] dd_mag;
  logic [DIVIDEND_W-1:0] quo;
  logic [DIVISOR_W-1:0]  dv_mag;
  logic [DIVISOR_W-1:0]  dd_lo;
  logic [DIVISOR_W:0]    part;
  logic                  q_neg;
  logic                  r_neg;
  logic                  dbz;
  logic                  ovf;

  logic [DIVIDEND_W-1:0] quotient_q;
  logic [DIVISOR_W-1:0]  remainder_q;
  logic                  dbz_q;
  logic                  ovf_q;
  logic                  out_valid_q;

  logic                  dd_sign;
  logic                  dv_sign;
  logic                  dv_zero;
  logic [DIVIDEND_W-1:0] dd_abs;
  logic [DIVISOR_W-1:0]  dv_abs;
  logic [DIVIDEND_W-1:0] q_fix;
  logic [DIVISOR_W-1:0]  r_fix;
  logic [DIVISOR_W+1:0]  shifted;
  logic [DIVISOR_W+1:0]  trial;
  logic                  q_bit;

  assign dd_sign = SIGNED && bus.dividend[DIVIDEND_W-1];
  assign dv_sign = SIGNED && bus.divisor[DIVISOR_W-1];
  assign dv_zero = (bus.divisor == '0);

  div_sign_mag #(.W(DIVIDEND_W), .SIGNED(SIGNED)) u_dd_abs (
    .val (bus.dividend),
    .neg (dd_sign),
    .res (dd_abs)
  );

  div_sign_mag #(.W(DIVISOR_W), .SIGNED(SIGNED)) u_dv_abs (
    .val (bus.divisor),
    .neg (dv_sign),
    .res (dv_abs)
  );

  div_sign_mag #(.W(DIVIDEND_W), .SIGNED(SIGNED)) u_q_fix (
    .val (quo),
    .neg (q_neg),
    .res (q_fix)
  );

  div_sign_mag #(.W(DIVISOR_W), .SIGNED(SIGNED)) u_r_fix (
    .val (part[DIVISOR_W-1:0]),
    .neg (r_neg),
    .res (r_fix)
  );

  // Partial remainder stays below the divisor magnitude, so one extra bit
  // of headroom makes the trial difference's MSB a valid borrow flag.
  assign shifted = {part, dd_mag[DIVIDEND_W-1]};
  assign trial   = shifted - {2'b00, dv_mag};
  assign q_bit   = ~trial[DIVISOR_W+1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      cnt         <= '0;
      dd_mag      <= '0;
      quo         <= '0;
      dv_mag      <= '0;
      dd_lo       <= '0;
      part        <= '0;
      q_neg       <= 1'b0;
      r_neg       <= 1'b0;
      dbz         <= 1'b0;
      ovf         <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (ce) begin
      case (state)
        S_IDLE: begin
          if (bus.in_valid) begin
            dd_mag <= dd_abs;
            dv_mag <= dv_abs;
            dd_lo  <= bus.dividend[DIVISOR_W-1:0];
            q_neg  <= dd_sign ^ dv_sign;
            r_neg  <= dd_sign;
            part   <= '0;
            quo    <= '0;
            cnt    <= CW'(DIVIDEND_W - 1);
            dbz    <= dv_zero;
            ovf    <= SIGNED && (bus.dividend == D_MIN) && (bus.divisor == '1);
            state  <= dv_zero ? S_FIX : S_CALC;
          end
        end
        S_CALC: begin
          part   <= q_bit ? trial[DIVISOR_W:0] : shifted[DIVISOR_W:0];
          quo    <= {quo[DIVIDEND_W-2:0], q_bit};
          dd_mag <= {dd_mag[DIVIDEND_W-2:0], 1'b0};
          if (cnt == '0) begin
            state <= S_FIX;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        S_FIX: begin
          dbz_q <= dbz;
          ovf_q <= ovf;
          if (dbz) begin
`ifdef DIV_SAT_EN
            quotient_q  <= SIGNED ? (r_neg ? D_MIN : Q_MAX) : '1;
            remainder_q <= '0;
`else
            quotient_q  <= '1;
            remainder_q <= dd_lo;
`endif
          end else begin
`ifdef DIV_SAT_EN
            quotient_q  <= ovf ? Q_MAX : q_fix;
`else
            quotient_q  <= q_fix;
`endif
            remainder_q <= r_fix;
          end
          state <= S_DONE;
        end
        S_DONE: begin
          // Results land first; valid rises a cycle later onto a settled bus.
          if (!out_valid_q) begin
            out_valid_q <= 1'b1;
          end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state       <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready    = (state == S_IDLE);
  assign bus.out_valid   = out_valid_q;
  assign bus.quotient    = quotient_q;
  assign bus.remainder   = remainder_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.overflow    = ovf_q;

endmodule

// File: tb/tb_div32x16_signed_seq.sv
// Directed bench for div32x16_signed_seq: latency, signs, divide-by-zero,
// MIN/-1, backpressure, ce gating and mid-operation reset; honours DIV_SAT_EN.
module tb_div32x16_signed_seq;

  logic clk = 1'b0;
  logic rst_n;
  logic ce;
  int   n_chk  = 0;
  int   n_fail = 0;
  int   lat;

  always #5 clk = ~clk;

  div32x16_signed_seq_if #(.DIVIDEND_W(32), .DIVISOR_W(16)) bus ();

  div32x16_signed_seq #(.DIVIDEND_W(32), .DIVISOR_W(16), .SIGNED(1'b1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ce    (ce),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  // Called at a negedge; returns at the negedge right after the accepting edge.
  task automatic start(input logic [31:0] a, input logic [15:0] b);
    int g = 0;
    while (bus.in_ready !== 1'b1 && g < 100) begin
      cyc(1);
      g++;
    end
    bus.dividend = a;
    bus.divisor  = b;
    bus.in_valid = 1'b1;
    cyc(1);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_valid(input int base, output int n);
    n = base;
    while (bus.out_valid !== 1'b1 && n < 200) begin
      cyc(1);
      n++;
    end
  endtask

  task automatic result(input string tag, input logic [31:0] q, input logic [15:0] r,
                        input logic dz, input logic ov);
    chk({tag, " quotient"}, bus.quotient, q);
    chk({tag, " remainder"}, bus.remainder, r);
    chk({tag, " div_by_zero"}, bus.div_by_zero, dz);
    chk({tag, " overflow"}, bus.overflow, ov);
  endtask

  initial begin
    rst_n         = 1'b0;
    ce            = 1'b1;
    bus.in_valid  = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;
    bus.out_ready = 1'b1;
    cyc(2);
    chk("reset in_ready", bus.in_ready, 1);
    chk("reset out_valid", bus.out_valid, 0);
    result("reset", 32'h0, 16'h0, 1'b0, 1'b0);
    rst_n = 1'b1;
    cyc(1);

    // 1000 / 7
    start(32'd1000, 16'd7);
    wait_valid(0, lat);
    chk("1000/7 latency", lat, 34);
    result("1000/7", 32'd142, 16'd6, 1'b0, 1'b0);
    cyc(1);
    chk("1000/7 handshake out_valid", bus.out_valid, 0);
    chk("1000/7 handshake in_ready", bus.in_ready, 1);

    // -1000 / 7 and -1000 / -7
    start(32'hFFFF_FC18, 16'd7);
    wait_valid(0, lat);
    chk("-1000/7 latency", lat, 34);
    result("-1000/7", 32'hFFFF_FF72, 16'hFFFA, 1'b0, 1'b0);
    cyc(1);
    start(32'hFFFF_FC18, 16'hFFF9);
    wait_valid(0, lat);
    result("-1000/-7", 32'd142, 16'hFFFA, 1'b0, 1'b0);
    cyc(1);

    // Divide by zero
    start(32'd5, 16'd0);
    wait_valid(0, lat);
    chk("5/0 latency", lat, 2);
`ifdef DIV_SAT_EN
    result("5/0", 32'h7FFF_FFFF, 16'h0, 1'b1, 1'b0);
`else
    result("5/0", 32'hFFFF_FFFF, 16'd5, 1'b1, 1'b0);
`endif
    cyc(1);
    start(32'hFFFF_FFFB, 16'd0);
    wait_valid(0, lat);
`ifdef DIV_SAT_EN
    result("-5/0", 32'h8000_0000, 16'h0, 1'b1, 1'b0);
`else
    result("-5/0", 32'hFFFF_FFFF, 16'hFFFB, 1'b1, 1'b0);
`endif
    cyc(1);

    // MIN / -1
    start(32'h8000_0000, 16'hFFFF);
    wait_valid(0, lat);
    chk("MIN/-1 latency", lat, 34);
`ifdef DIV_SAT_EN
    result("MIN/-1", 32'h7FFF_FFFF, 16'h0, 1'b0, 1'b1);
`else
    result("MIN/-1", 32'h8000_0000, 16'h0, 1'b0, 1'b1);
`endif
    cyc(1);

    // Backpressure: 123456 / -100 held for 10 cycles, stray in_valid ignored
    bus.out_ready = 1'b0;
    start(32'd123456, 16'hFF9C);
    wait_valid(0, lat);
    chk("bp latency", lat, 34);
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = ~i[0];
      bus.dividend = 32'd7;
      bus.divisor  = 16'd1;
      cyc(1);
      chk("bp out_valid held", bus.out_valid, 1);
      chk("bp in_ready low", bus.in_ready, 0);
      chk("bp quotient stable", bus.quotient, 32'hFFFF_FB2E);
    end
    bus.in_valid = 1'b0;
    chk("bp remainder", bus.remainder, 16'd56);
    // ce=0 blocks the handshake even with out_ready high
    bus.out_ready = 1'b1;
    ce = 1'b0;
    cyc(3);
    chk("ce0 out_valid held", bus.out_valid, 1);
    ce = 1'b1;
    cyc(1);
    chk("ce1 handshake out_valid", bus.out_valid, 0);
    chk("ce1 handshake in_ready", bus.in_ready, 1);

    // ce dropped for 5 cycles mid-CALC: 100000 / -3
    start(32'd100000, 16'hFFFD);
    cyc(10);
    ce = 1'b0;
    cyc(5);
    ce = 1'b1;
    wait_valid(15, lat);
    chk("ce gap latency", lat, 39);
    result("100000/-3", 32'hFFFF_7DCB, 16'd1, 1'b0, 1'b0);
    cyc(1);

    // Reset at CALC cycle 12, then a clean 65535 / 255
    start(32'd1000, 16'd7);
    cyc(12);
    rst_n = 1'b0;
    #1;
    chk("midrst out_valid", bus.out_valid, 0);
    chk("midrst in_ready", bus.in_ready, 1);
    cyc(2);
    rst_n = 1'b1;
    cyc(1);
    chk("post-rst out_valid", bus.out_valid, 0);
    chk("post-rst in_ready", bus.in_ready, 1);
    result("post-rst", 32'h0, 16'h0, 1'b0, 1'b0);
    start(32'd65535, 16'd255);
    wait_valid(0, lat);
    chk("65535/255 latency", lat, 34);
    result("65535/255", 32'd257, 16'd0, 1'b0, 1'b0);
    cyc(1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
